// File: rtl/udma_filter_tx_arb_pkg.sv
// Shared types and constants for the filter TX-channel arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udma_filter_tx_arb_pkg;

    localparam int FILT_TX_NREQ      = 2;
    localparam int FILT_DATA_WIDTH   = 32;
    localparam int FILT_L2_AWIDTH    = 19;
    localparam int FILT_OUTSTD_DEPTH = 4;

    // Requester index: 0 = ch0, 1 = ch1.
    typedef logic filt_tx_id_t;

    // Request phase payload as forwarded to the uDMA TX channel.
    typedef struct packed {
        logic [FILT_L2_AWIDTH-1:0] addr;
        logic [1:0]                datasize;
    } filt_tx_req_t;

    // With two requesters the round-robin successor is the other one.
    function automatic filt_tx_id_t filt_tx_other(input filt_tx_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/udma_filter_tx_arb_if.sv
// Single uDMA TX channel: request/grant phase plus valid/ready data return.
// Latency: n/a (wires only).
// Backpressure: tx_ready from the master side throttles returned beats.
// Ports: tx_req/tx_addr/tx_datasize/tx_ready driven by master; tx_gnt/tx_valid/tx_data by slave.
interface udma_filter_tx_arb_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 19
);
    logic                      tx_req;
    logic [L2_AWIDTH_NOAL-1:0] tx_addr;
    logic [1:0]                tx_datasize;
    logic                      tx_gnt;
    logic                      tx_valid;
    logic [DATA_WIDTH-1:0]     tx_data;
    logic                      tx_ready;

    modport master (
        output tx_req, tx_addr, tx_datasize, tx_ready,
        input  tx_gnt, tx_valid, tx_data
    );

    modport slave (
        input  tx_req, tx_addr, tx_datasize, tx_ready,
        output tx_gnt, tx_valid, tx_data
    );
endinterface

// File: rtl/udma_filter_tx_order_fifo.sv
// In-order FIFO holding the IDs of granted-but-unreturned requests.
// Latency: push visible at head one cycle later; pop takes effect at the clock edge.
// Backpressure: caller must not push when full_o or pop when empty_o.
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i, pop_i, full_o, empty_o, count_o, head_o.
module udma_filter_tx_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr] <= din_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wr <= r_wr + 1'b1;
            if (pop_i)  r_rd <= r_rd + 1'b1;
            case ({push_i, pop_i})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign count_o = r_cnt;
    assign head_o  = r_mem[r_rd];

endmodule

// File: rtl/udma_filter_tx_arb.sv
// Round-robin share of one uDMA TX channel between filter ports ch0/ch1; returned beats routed by grant order.
// Latency: req->tx_req and tx_gnt->gnt_o are combinational; data path is combinational pass-through.
// Backpressure: no new request while OUTSTD_DEPTH grants are outstanding; tx_ready_o follows the head requester's ready.
// Ports: clk_i/rst_i, per-requester req/addr/datasize/gnt/valid/ready, broadcast data_o, upstream channel tx, err_o, outstd_o.
module udma_filter_tx_arb
    import udma_filter_tx_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = FILT_DATA_WIDTH,
    parameter int L2_AWIDTH_NOAL = FILT_L2_AWIDTH,
    parameter int OUTSTD_DEPTH   = FILT_OUTSTD_DEPTH
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [FILT_TX_NREQ-1:0]                       req_i,
    input  logic [FILT_TX_NREQ-1:0][L2_AWIDTH_NOAL-1:0]   addr_i,
    input  logic [FILT_TX_NREQ-1:0][1:0]                  datasize_i,
    output logic [FILT_TX_NREQ-1:0]                       gnt_o,
    output logic [FILT_TX_NREQ-1:0]                       valid_o,
    output logic [DATA_WIDTH-1:0]                         data_o,
    input  logic [FILT_TX_NREQ-1:0]                       ready_i,
    udma_filter_tx_arb_if.master                          tx,
    output logic                                          err_o,
    output logic [$clog2(OUTSTD_DEPTH):0]                 outstd_o
);
    logic         r_lock;
    filt_tx_id_t  r_win;
    filt_tx_id_t  r_ptr;
    logic         r_err;

    filt_tx_id_t  w_win;
    filt_tx_id_t  w_head;
    filt_tx_req_t w_sel;
    logic         w_full;
    logic         w_empty;
    logic         w_tx_req;
    logic         w_hs;
    logic         w_pop;
    logic         w_lock_drop;

    // A held selection is honoured only while its owner still requests; if it
    // dropped, the arbitration falls back to the live requests this cycle.
    always_comb begin
        w_win = r_ptr;
        if (r_lock && req_i[r_win]) begin
            w_win = r_win;
        end else if (req_i == 2'b01) begin
            w_win = 1'b0;
        end else if (req_i == 2'b10) begin
            w_win = 1'b1;
        end
    end

    assign w_tx_req    = (|req_i) & ~w_full;
    assign w_hs        = w_tx_req & tx.tx_gnt;
    assign w_lock_drop = r_lock & ~req_i[r_win];
    assign w_sel       = '{addr: addr_i[w_win], datasize: datasize_i[w_win]};

    // Address/size are zeroed when not requesting so idle outputs stay quiet.
    assign tx.tx_req      = w_tx_req;
    assign tx.tx_addr     = w_tx_req ? w_sel.addr : '0;
    assign tx.tx_datasize = w_tx_req ? w_sel.datasize : '0;

    always_comb begin
        gnt_o = '0;
        if (w_hs) gnt_o[w_win] = 1'b1;
    end

    // Beats arriving with nothing outstanding are accepted and dropped.
    assign tx.tx_ready = w_empty | ready_i[w_head];
    assign w_pop       = tx.tx_valid & ~w_empty & ready_i[w_head];
    assign data_o      = tx.tx_data;

    always_comb begin
        valid_o = '0;
        if (!w_empty) valid_o[w_head] = tx.tx_valid;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock <= 1'b0;
            r_win  <= 1'b0;
            r_ptr  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            // Lock exactly when a request is presented but not yet granted.
            r_lock <= w_tx_req & ~tx.tx_gnt;
            if (w_tx_req) r_win <= w_win;
            if (w_hs)     r_ptr <= filt_tx_other(w_win);
            if (w_lock_drop || (tx.tx_valid && w_empty)) r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    udma_filter_tx_order_fifo #(
        .DEPTH (OUTSTD_DEPTH),
        .WIDTH (1)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .din_i   (w_win),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstd_o),
        .head_o  (w_head)
    );

endmodule

// File: tb/tb_udma_filter_tx_arb.sv
// Bench for udma_filter_tx_arb: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference of grant order and routing rules.
module tb_udma_filter_tx_arb;
    import udma_filter_tx_arb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 19;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [1:0]              req;
    logic [1:0][AW-1:0]      addr;
    logic [1:0][1:0]         ds;
    logic [1:0]              ready;
    logic [1:0]              gnt_o;
    logic [1:0]              valid_o;
    logic [DW-1:0]           data_o;
    logic                    err_o;
    logic [2:0]              outstd_o;

    udma_filter_tx_arb_if #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW)) tx_if ();

    udma_filter_tx_arb #(
        .DATA_WIDTH     (DW),
        .L2_AWIDTH_NOAL (AW),
        .OUTSTD_DEPTH   (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .addr_i     (addr),
        .datasize_i (ds),
        .gnt_o      (gnt_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready),
        .tx         (tx_if),
        .err_o      (err_o),
        .outstd_o   (outstd_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: queue of granted IDs in grant order, round-robin favourite,
    // pending (presented but ungranted) requester or -1, sticky error.
    int q[$];
    int m_ptr;
    int m_pend;
    bit m_err;

    // Outputs sampled mid-cycle by the last call to cycle().
    logic [1:0]    s_gnt, s_valid;
    logic          s_txreq, s_txrdy, s_err;
    logic [2:0]    s_outstd;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        ready = 2'b00;
        tx_if.tx_gnt = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ptr = 0;
        m_pend = -1;
        m_err = 1'b0;
        @(negedge clk);
        chk("rst_outstd", outstd_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_txreq", tx_if.tx_req, 0);
        chk("rst_txaddr", tx_if.tx_addr, 0);
        chk("rst_txready", tx_if.tx_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs, check every output against the reference, advance.
    task automatic cycle(input logic [1:0] r, input logic g, input logic v,
                         input logic [1:0] rd, input logic [DW-1:0] d);
        int         win;
        int         head;
        bit         full, treq, hs, pop;
        logic [1:0] e_gnt, e_valid;
        logic       e_rdy;
        req = r;
        tx_if.tx_gnt = g;
        tx_if.tx_valid = v;
        ready = rd;
        tx_if.tx_data = d;

        full = (q.size() == DEPTH);
        if (m_pend >= 0 && r[m_pend]) win = m_pend;
        else if (r == 2'b01)            win = 0;
        else if (r == 2'b10)            win = 1;
        else                            win = m_ptr;
        treq  = (r != 2'b00) && !full;
        hs    = treq && g;
        e_gnt = hs ? 2'(1 << win) : 2'b00;
        if (q.size() == 0) begin
            e_rdy = 1'b1;
            e_valid = 2'b00;
            pop = 1'b0;
        end else begin
            head = q[0];
            e_rdy = rd[head];
            e_valid = v ? 2'(1 << head) : 2'b00;
            pop = v && rd[head];
        end

        @(negedge clk);
        s_gnt = gnt_o;  s_valid = valid_o;  s_txreq = tx_if.tx_req;
        s_txrdy = tx_if.tx_ready;  s_err = err_o;  s_outstd = outstd_o;
        s_addr = tx_if.tx_addr;  s_data = data_o;
        chk("tx_req", s_txreq, treq);
        chk("tx_addr", s_addr, treq ? addr[win] : '0);
        chk("tx_datasize", tx_if.tx_datasize, treq ? ds[win] : 2'b00);
        chk("gnt", s_gnt, e_gnt);
        chk("valid", s_valid, e_valid);
        chk("tx_ready", s_txrdy, e_rdy);
        chk("data", s_data, d);
        chk("outstd", s_outstd, q.size());
        chk("err", s_err, m_err);
        @(posedge clk);
        #1;

        if (m_pend >= 0 && !r[m_pend]) m_err = 1'b1;
        if (v && q.size() == 0)        m_err = 1'b1;
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(win);
            m_ptr = 1 - win;
        end
        m_pend = (treq && !g) ? win : -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        addr = '0;
        ds = '0;

        // 1: single requester, one beat returned.
        do_reset();
        addr[0] = 19'h0_1234;  ds[0] = 2'd2;
        cycle(2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("t1_gnt", s_gnt, 2'b01);
        cycle(2'b00, 1'b0, 1'b1, 2'b01, 32'hA5A5_A5A5);
        chk("t1_valid", s_valid, 2'b01);
        chk("t1_data", s_data, 32'hA5A5_A5A5);

        // 2: both requesting, grants alternate; beats return in grant order.
        do_reset();
        addr[1] = 19'h4_5678;  ds[1] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            cycle(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
            chk("t2_gnt", s_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 1'b0, 1'b1, 2'b11, DW'(i + 1));
            chk("t2_valid", s_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // 3: ch1 wins and is held through 3 stalled cycles despite ch0 arriving.
        do_reset();
        addr[0] = 19'h1_1111;  addr[1] = 19'h2_2222;
        cycle(2'b10, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t3_addr_a", s_addr, 19'h2_2222);
        cycle(2'b11, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t3_addr_b", s_addr, 19'h2_2222);
        cycle(2'b11, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t3_addr_c", s_addr, 19'h2_2222);
        cycle(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("t3_gnt", s_gnt, 2'b10);

        // 4: full FIFO blocks requests, even in the cycle a pop happens.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
        cycle(2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("t4_full_req", s_txreq, 1'b0);
        chk("t4_full_cnt", s_outstd, 3'd4);
        cycle(2'b01, 1'b1, 1'b1, 2'b01, 32'h55);
        chk("t4_pop_req", s_txreq, 1'b0);
        chk("t4_pop_gnt", s_gnt, 2'b00);
        cycle(2'b01, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("t4_rearm_req", s_txreq, 1'b1);
        chk("t4_rearm_gnt", s_gnt, 2'b01);

        // 5: head is ch1; only ch1's ready may pop.
        do_reset();
        cycle(2'b10, 1'b1, 1'b0, 2'b00, 32'h0);
        cycle(2'b00, 1'b0, 1'b1, 2'b01, 32'h77);
        chk("t5_stall_rdy", s_txrdy, 1'b0);
        chk("t5_stall_valid", s_valid, 2'b10);
        cycle(2'b00, 1'b0, 1'b1, 2'b10, 32'h78);
        chk("t5_go_rdy", s_txrdy, 1'b1);
        cycle(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t5_drained", s_outstd, 3'd0);

        // 6: stray beat sets sticky error; reset mid-burst clears everything.
        do_reset();
        cycle(2'b00, 1'b0, 1'b1, 2'b00, 32'hDEAD);
        cycle(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t6_err_set", s_err, 1'b1);
        cycle(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t6_err_sticky", s_err, 1'b1);
        cycle(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
        cycle(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
        cycle(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t6_outstd2", s_outstd, 3'd2);
        do_reset();

        // Randomized traffic; occasional resets and protocol violations.
        for (int n = 0; n < 500; n++) begin
            logic [1:0] r;
            logic       v;
            if ($urandom_range(0, 79) == 0) do_reset();
            addr[0] = AW'($urandom);  addr[1] = AW'($urandom);
            ds[0] = 2'($urandom);     ds[1] = 2'($urandom);
            r = 2'($urandom);
            if (m_pend >= 0 && $urandom_range(0, 19) != 0) r[m_pend] = 1'b1;
            v = (q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 29) == 0);
            cycle(r, $urandom_range(0, 3) != 0, v, 2'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
